// File: rtl/smvm_pkg.sv
// -----------------------------------------------------------------------------
// smvm_pkg
// Shared definitions for the SMVM CSR packer: controller state encoding,
// the 12-bit header/index word and its val/ipv/col split, the buffered
// non-zero entry layout, and the default buffer depths.
// -----------------------------------------------------------------------------
package smvm_pkg;

    localparam int unsigned MAX_COLS_DEF = 128;
    localparam int unsigned MAX_NNZ_DEF  = 64;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_VEC,
        ST_LD_MAT,
        ST_E_ROWS,
        ST_E_COLS,
        ST_E_VEC,
        ST_E_VAL,
        ST_E_IDX,
        ST_DONE
    } state_t;

    // Engine-side word: val_out = W[11:4], ipv_out = W[3], col_out = W[2:0]
    typedef logic [11:0] hdr_word_t;

    typedef struct packed {
        logic [7:0] val;
        logic [6:0] col;
        logic       ipv;
    } nnz_entry_t;

    function automatic logic [7:0] hdr_val(input hdr_word_t w);
        return w[11:4];
    endfunction

    function automatic logic hdr_ipv(input hdr_word_t w);
        return w[3];
    endfunction

    function automatic logic [2:0] hdr_col(input hdr_word_t w);
        return w[2:0];
    endfunction

endpackage

// File: rtl/smvm_nnz_buf.sv
// -----------------------------------------------------------------------------
// smvm_nnz_buf
// MAX_NNZ-entry register file holding the compressed matrix entries.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   full-entry write port
//   set_en/set_addr         sets the ipv bit of an already stored entry
//   rd_addr/rd_data         combinational read port
// Contents are not reset; only slots below the live entry count are read.
// -----------------------------------------------------------------------------
module smvm_nnz_buf
    import smvm_pkg::*;
#(
    parameter int unsigned MAX_NNZ = MAX_NNZ_DEF,
    parameter int unsigned AW      = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  nnz_entry_t    wr_data,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] rd_addr,
    output nnz_entry_t    rd_data
);

    nnz_entry_t mem [MAX_NNZ];

    // The controller never aims both ports at one slot in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (set_en) begin
            mem[set_addr].ipv <= 1'b1;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/smvm_csr_packer.sv
// -----------------------------------------------------------------------------
// smvm_csr_packer
// Upstream feeder for the SMVM engine. Loads a dense vector and a dense
// row-major matrix over a valid/ready stream, compresses the matrix to
// non-zero VAL/IDX entries with a per-row ipv end flag, then replays the
// whole job to the engine as one gap-free burst:
//   rows header, cols header, cols vector words, VAL/IDX pairs, one idle cycle.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_start/cfg_rows/cfg_cols job start pulse and dimensions (IDLE only)
//   s_valid/s_ready/s_data      element stream: vector first, then matrix
//   val_out/col_out/ipv_out/out_valid   engine input bus
//   busy                        job in progress
//   err_overflow                sticky, a non-zero or zero-row marker entry was dropped
//   stat_nnz/stat_zero_rows     only when PACKER_STATS_EN is defined
// Optional build macro: PACKER_STATS_EN
// -----------------------------------------------------------------------------
module smvm_csr_packer
    import smvm_pkg::*;
#(
    parameter int unsigned MAX_COLS = MAX_COLS_DEF,
    parameter int unsigned MAX_NNZ  = MAX_NNZ_DEF,
    parameter int unsigned DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [7:0]    cfg_rows,
    input  logic [7:0]    cfg_cols,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [7:0]    val_out,
    output logic [2:0]    col_out,
    output logic          ipv_out,
    output logic          out_valid,
    output logic          busy,
`ifdef PACKER_STATS_EN
    output logic [7:0]    stat_nnz,
    output logic [7:0]    stat_zero_rows,
`endif
    output logic          err_overflow
);

    localparam int unsigned VAW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int unsigned AW  = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
    localparam int unsigned CW  = $clog2(MAX_NNZ + 1);

    state_t         state_q, state_d;
    logic [7:0]     rows_q, cols_q;
    logic [7:0]     cnt;
    logic [7:0]     r, c;
    logic [CW-1:0]  nnz;
    logic [CW-1:0]  rd_idx;
    logic [AW-1:0]  last_in_row;
    logic           row_nz;
    logic           err_q;
    logic [7:0]     vec_mem [MAX_COLS];
    logic [7:0]     elem_val;
    hdr_word_t      word;

    logic           xfer, mat_xfer, is_nz, row_end, full, need_write;
    logic           wr_en, set_en;
    nnz_entry_t     wr_data, rd_data;

`ifdef PACKER_STATS_EN
    logic [7:0]     zero_rows;
`endif

    assign elem_val = 8'($signed(s_data));
    assign xfer     = s_valid && s_ready;
    assign mat_xfer = xfer && (state_q == ST_LD_MAT);
    assign is_nz    = (s_data != '0);
    assign row_end  = (c == cols_q - 8'd1);
    assign full     = (nnz == CW'(MAX_NNZ));

    // A row with no non-zero still needs one entry to carry its ipv flag.
    assign need_write = mat_xfer && (is_nz || (row_end && !row_nz));
    assign wr_en      = need_write && !full;

    always_comb begin
        wr_data     = '0;
        wr_data.ipv = row_end;
        if (is_nz) begin
            wr_data.val = elem_val;
            wr_data.col = c[6:0];
        end
    end

    // Close the row on the last stored entry whenever the closing element
    // did not itself get stored (zero, or dropped on overflow). On overflow
    // this keeps re-marking the final stored entry, so framing survives.
    assign set_en = mat_xfer && row_end && (row_nz || is_nz) && !(is_nz && !full);

    smvm_nnz_buf #(
        .MAX_NNZ (MAX_NNZ),
        .AW      (AW)
    ) u_nnz_buf (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (nnz[AW-1:0]),
        .wr_data  (wr_data),
        .set_en   (set_en),
        .set_addr (last_in_row),
        .rd_addr  (rd_idx[AW-1:0]),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_LD_VEC && xfer) begin
            vec_mem[cnt[VAW-1:0]] <= elem_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        out_valid = 1'b0;
        word      = '0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) state_d = ST_LD_VEC;
            end
            ST_LD_VEC: begin
                s_ready = 1'b1;
                if (s_valid && cnt == cols_q - 8'd1) state_d = ST_LD_MAT;
            end
            ST_LD_MAT: begin
                s_ready = 1'b1;
                if (s_valid && row_end && r == rows_q - 8'd1) state_d = ST_E_ROWS;
            end
            ST_E_ROWS: begin
                out_valid = 1'b1;
                word      = {4'h0, rows_q};
                state_d   = ST_E_COLS;
            end
            ST_E_COLS: begin
                out_valid = 1'b1;
                word      = {4'h0, cols_q};
                state_d   = ST_E_VEC;
            end
            ST_E_VEC: begin
                out_valid = 1'b1;
                word      = {vec_mem[cnt[VAW-1:0]], 4'h0};
                if (cnt == cols_q - 8'd1) begin
                    state_d = (nnz == '0) ? ST_DONE : ST_E_VAL;
                end
            end
            ST_E_VAL: begin
                out_valid = 1'b1;
                word      = {rd_data.val, rd_data.ipv, 3'b000};
                state_d   = ST_E_IDX;
            end
            ST_E_IDX: begin
                out_valid = 1'b1;
                word      = {5'b00000, rd_data.col};
                state_d   = (rd_idx == nnz - CW'(1)) ? ST_DONE : ST_E_VAL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q      <= '0;
            cols_q      <= '0;
            cnt         <= '0;
            r           <= '0;
            c           <= '0;
            nnz         <= '0;
            rd_idx      <= '0;
            last_in_row <= '0;
            row_nz      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PACKER_STATS_EN
            zero_rows   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        rows_q    <= cfg_rows;
                        cols_q    <= cfg_cols;
                        cnt       <= '0;
                        r         <= '0;
                        c         <= '0;
                        nnz       <= '0;
                        rd_idx    <= '0;
                        row_nz    <= 1'b0;
                        err_q     <= 1'b0;
`ifdef PACKER_STATS_EN
                        zero_rows <= '0;
`endif
                    end
                end
                ST_LD_VEC: begin
                    if (xfer) begin
                        cnt <= (cnt == cols_q - 8'd1) ? 8'd0 : cnt + 8'd1;
                    end
                end
                ST_LD_MAT: begin
                    if (xfer) begin
                        if (wr_en) begin
                            nnz <= nnz + CW'(1);
                            if (is_nz) last_in_row <= nnz[AW-1:0];
                        end
                        if (need_write && full) begin
                            err_q <= 1'b1;
                        end
                        if (row_end) begin
                            c      <= '0;
                            r      <= r + 8'd1;
                            row_nz <= 1'b0;
`ifdef PACKER_STATS_EN
                            if (!row_nz && !is_nz) zero_rows <= zero_rows + 8'd1;
`endif
                        end else begin
                            c <= c + 8'd1;
                            if (is_nz) row_nz <= 1'b1;
                        end
                    end
                end
                ST_E_VEC: begin
                    cnt <= cnt + 8'd1;
                end
                ST_E_IDX: begin
                    rd_idx <= rd_idx + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign err_overflow = err_q;
    assign val_out      = hdr_val(word);
    assign ipv_out      = hdr_ipv(word);
    assign col_out      = hdr_col(word);

`ifdef PACKER_STATS_EN
    assign stat_nnz       = 8'(nnz);
    assign stat_zero_rows = zero_rows;
`endif

endmodule

// File: tb/tb_smvm_csr_packer.sv
// -----------------------------------------------------------------------------
// tb_smvm_csr_packer
// Directed bench for smvm_csr_packer built with a 4-entry non-zero buffer.
// Each job pushes its expected engine words into a scoreboard queue from a
// reference model, then pops and compares them while out_valid is high.
// -----------------------------------------------------------------------------
module tb_smvm_csr_packer;

    localparam int TB_MAX_NNZ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_rows = '0;
    logic [7:0] cfg_cols = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic [7:0] val_out;
    logic [2:0] col_out;
    logic       ipv_out;
    logic       out_valid;
    logic       busy;
    logic       err_overflow;

    always #5 clk = ~clk;

    smvm_csr_packer #(
        .MAX_COLS (128),
        .MAX_NNZ  (TB_MAX_NNZ),
        .DW       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_rows     (cfg_rows),
        .cfg_cols     (cfg_cols),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .val_out      (val_out),
        .col_out      (col_out),
        .ipv_out      (ipv_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  vec_a [128];
    logic [7:0]  mat_a [512];
    logic        exp_err;
    int          exp_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: compress row by row, cap at the buffer depth, flag row ends.
    task automatic build_expected(input int rows, input int cols);
        logic [7:0] ev[$];
        logic [6:0] ec[$];
        logic       ei[$];
        bit         seen;
        exp_q.delete();
        exp_err = 1'b0;
        for (int rr = 0; rr < rows; rr++) begin
            seen = 1'b0;
            for (int cc = 0; cc < cols; cc++) begin
                if (mat_a[rr*cols+cc] != 8'h00) begin
                    seen = 1'b1;
                    if (ev.size() < TB_MAX_NNZ) begin
                        ev.push_back(mat_a[rr*cols+cc]);
                        ec.push_back(7'(cc));
                        ei.push_back(1'b0);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
            if (seen) begin
                ei[ei.size()-1] = 1'b1;
            end else if (ev.size() < TB_MAX_NNZ) begin
                ev.push_back(8'h00);
                ec.push_back(7'd0);
                ei.push_back(1'b1);
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_q.push_back({4'h0, 8'(rows)});
        exp_q.push_back({4'h0, 8'(cols)});
        for (int i = 0; i < cols; i++) exp_q.push_back({vec_a[i], 4'h0});
        for (int k = 0; k < ev.size(); k++) begin
            exp_q.push_back({ev[k], ei[k], 3'b000});
            exp_q.push_back({5'b00000, ec[k]});
        end
        exp_len = exp_q.size();
    endtask

    // s_ready depends on state only, so its negedge value decides the next edge.
    task automatic drive_elem(input logic [7:0] d, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 50 && !s_ready; t++) @(negedge clk);
        chk("s_ready_load", s_ready, 1);
        @(negedge clk);
    endtask

    task automatic run_job(input int rows, input int cols, input bit stall,
                           input int pulse_at, input int abort_at);
        int n;
        logic [11:0] w;
        build_expected(rows, cols);
        cfg_rows  = 8'(rows);
        cfg_cols  = 8'(cols);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < cols; i++) drive_elem(vec_a[i], stall);
        for (int i = 0; i < rows*cols; i++) drive_elem(mat_a[i], stall);
        s_valid = 1'b0;
        s_data  = '0;
        chk("first_out_latency", out_valid, 1);
        n = 0;
        while (out_valid && n < 1000) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_err", err_overflow, 0);
                chk("abort_s_ready", s_ready, 0);
                return;
            end
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            chk($sformatf("stream[%0d]", n), {val_out, ipv_out, col_out}, w);
            if (n == pulse_at) begin
                cfg_rows  = 8'd7;
                cfg_cols  = 8'd3;
                cfg_start = 1'b1;
            end
            @(negedge clk);
            cfg_start = 1'b0;
            n++;
        end
        chk("stream_len", n, exp_len);
        chk("done_busy", busy, 0);
        chk("err_overflow", err_overflow, exp_err);
        @(negedge clk);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    task automatic set_basic();
        logic [7:0] v[4]  = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0] m[8]  = '{8'd0, 8'd5, 8'd0, 8'hFF, 8'd7, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) vec_a[i] = v[i];
        for (int i = 0; i < 8; i++) mat_a[i] = m[i];
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_word", {val_out, ipv_out, col_out}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 2x4 job
        set_basic();
        run_job(2, 4, 1'b0, -1, -1);

        // 3x2 with an all-zero middle row
        vec_a[0] = 8'd10; vec_a[1] = 8'hF6;
        mat_a[0] = 8'd3;  mat_a[1] = 8'd0;
        mat_a[2] = 8'd0;  mat_a[3] = 8'd0;
        mat_a[4] = 8'd0;  mat_a[5] = 8'hFE;
        run_job(3, 2, 1'b0, -1, -1);

        // Basic job again with random source stalls
        set_basic();
        run_job(2, 4, 1'b1, -1, -1);

        // Dense 2x4 overflowing the 4-entry buffer
        for (int i = 0; i < 8; i++) mat_a[i] = 8'd1;
        run_job(2, 4, 1'b0, -1, -1);

        // Wide header (cols=100) with a cfg_start pulse during emission
        for (int i = 0; i < 100; i++) begin
            vec_a[i] = 8'(i + 1);
            mat_a[i] = 8'd0;
        end
        mat_a[40] = 8'hFD;
        mat_a[99] = 8'd9;
        run_job(1, 100, 1'b0, 6, -1);

        // Overflowing job aborted by reset during vector emission
        for (int i = 0; i < 4; i++) vec_a[i] = 8'(i + 1);
        for (int i = 0; i < 8; i++) mat_a[i] = 8'd1;
        run_job(2, 4, 1'b0, -1, 3);
        @(negedge clk);
        chk("held_rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh job after the abort
        set_basic();
        run_job(2, 4, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
